// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
package mc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXE_R    = 4'd2,
    ST_EXE_I    = 4'd3,
    ST_ALU_WB   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WB   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_ERROR    = 4'd11
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;
  localparam logic [1:0] SA_PC     = 2'b00;
  localparam logic [1:0] SA_RS1    = 2'b01;
  localparam logic [1:0] SA_OLDPC  = 2'b10;
  localparam logic [1:0] SB_RS2    = 2'b00;
  localparam logic [1:0] SB_IMM    = 2'b01;
  localparam logic [1:0] SB_FOUR   = 2'b10;
  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_J     = 3'b011;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath/memory bundle; master is the control FSM, slave the datapath side.
interface mc_ctrl_fsm_if #(parameter int CNT_W = 32);
  logic [6:0]       i_opcode;
  logic [2:0]       i_funct3;
  logic             i_funct7_5;
  logic             i_zero;
  logic             i_mem_ready;
  logic             o_mem_req;
  logic             o_mem_we;
  logic             o_ir_we;
  logic             o_pc_we;
  logic [1:0]       o_pc_src;
  logic             o_reg_we;
  logic [1:0]       o_wb_sel;
  logic [1:0]       o_alu_src_a;
  logic [1:0]       o_alu_src_b;
  logic [2:0]       o_imm_sel;
  logic [2:0]       o_alu_op;
  logic             o_err;
  logic [CNT_W-1:0] o_instret;

  modport master (
    input  i_opcode, i_funct3, i_funct7_5, i_zero, i_mem_ready,
    output o_mem_req, o_mem_we, o_ir_we, o_pc_we, o_pc_src, o_reg_we, o_wb_sel,
           o_alu_src_a, o_alu_src_b, o_imm_sel, o_alu_op, o_err, o_instret
  );

  modport slave (
    output i_opcode, i_funct3, i_funct7_5, i_zero, i_mem_ready,
    input  o_mem_req, o_mem_we, o_ir_we, o_pc_we, o_pc_src, o_reg_we, o_wb_sel,
           o_alu_src_a, o_alu_src_b, o_imm_sel, o_alu_op, o_err, o_instret
  );
endinterface

// File: rtl/mc_ctrl_fsm_alu_op_dec.sv
// ALU operation decode for R/I arithmetic instructions; flags encodings this core does not implement.
module mc_ctrl_fsm_alu_op_dec
  import mc_ctrl_fsm_pkg::*;
(
  input  logic       i_is_r,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output logic [2:0] o_alu_op,
  output logic       o_illegal
);

  always_comb begin
    o_alu_op  = ALU_ADD;
    o_illegal = 1'b0;
    case (i_funct3)
      3'b000: o_alu_op = (i_is_r && i_funct7_5) ? ALU_SUB : ALU_ADD;
      3'b100: o_alu_op = ALU_XOR;
      3'b110: o_alu_op = ALU_OR;
      3'b111: o_alu_op = ALU_AND;
      3'b010: o_alu_op = ALU_SLT;
      // sra / I-type funct7_5 on shift are not supported
      3'b101: begin
        o_alu_op  = ALU_SRL;
        o_illegal = i_funct7_5;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control FSM: sequences fetch..writeback, drives ALU op and datapath strobes,
// times out stalled memory accesses and counts retired instructions.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic           clk,
  input  logic           rst,
  mc_ctrl_fsm_if.master  bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_instret;
  logic              r_err;
  logic              w_in_mem;
  logic              w_enter_mem;
  logic              w_retire;
  logic              w_timeout;
  logic [2:0]        w_dec_op;
  logic              w_dec_illegal;

  mc_ctrl_fsm_alu_op_dec u_alu_op_dec (
    .i_is_r     (r_state == ST_EXE_R),
    .i_funct3   (bus.i_funct3),
    .i_funct7_5 (bus.i_funct7_5),
    .o_alu_op   (w_dec_op),
    .o_illegal  (w_dec_illegal)
  );

  assign w_in_mem  = (r_state inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR});
  assign w_timeout = (r_wait == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH:
        if (bus.i_mem_ready)  w_next = ST_DECODE;
        else if (w_timeout)   w_next = ST_ERROR;
      ST_DECODE:
        case (bus.i_opcode)
          OPC_R:               w_next = ST_EXE_R;
          OPC_I:               w_next = ST_EXE_I;
          OPC_LOAD, OPC_STORE: w_next = ST_MEM_ADDR;
          OPC_BRANCH:          w_next = ST_BRANCH;
          OPC_JAL:             w_next = ST_JAL;
          default:             w_next = ST_ERROR;
        endcase
      ST_EXE_R, ST_EXE_I: w_next = w_dec_illegal ? ST_ERROR : ST_ALU_WB;
      ST_ALU_WB:          w_next = ST_FETCH;
      ST_MEM_ADDR:
        if (bus.i_funct3 != 3'b010)        w_next = ST_ERROR;
        else if (bus.i_opcode == OPC_LOAD) w_next = ST_MEM_RD;
        else                               w_next = ST_MEM_WR;
      ST_MEM_RD:
        if (bus.i_mem_ready)  w_next = ST_MEM_WB;
        else if (w_timeout)   w_next = ST_ERROR;
      ST_MEM_WB:          w_next = ST_FETCH;
      ST_MEM_WR:
        if (bus.i_mem_ready)  w_next = ST_FETCH;
        else if (w_timeout)   w_next = ST_ERROR;
      ST_BRANCH:          w_next = (bus.i_funct3[2:1] == 2'b00) ? ST_FETCH : ST_ERROR;
      ST_JAL:             w_next = ST_FETCH;
      default:            w_next = ST_ERROR;
    endcase
  end

  // Only the retiring states ever move into FETCH, so any such move retires one instruction.
  assign w_retire    = (w_next == ST_FETCH) && (r_state != ST_FETCH);
  assign w_enter_mem = (w_next inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR}) && (w_next != r_state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_wait    <= WAIT_W'(MEM_TIMEOUT);
      r_instret <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_enter_mem)
        r_wait <= WAIT_W'(MEM_TIMEOUT);
      else if (w_in_mem && !bus.i_mem_ready && !w_timeout)
        r_wait <= r_wait - 1'b1;
      if (w_retire)
        r_instret <= r_instret + CNT_W'(1);
      if (w_next == ST_ERROR)
        r_err <= 1'b1;
    end
  end

  assign bus.o_err     = r_err;
  assign bus.o_instret = r_instret;

  // Strobes are forced idle while rst is high so memory sees the request drop at once.
  always_comb begin
    bus.o_mem_req   = 1'b0;
    bus.o_mem_we    = 1'b0;
    bus.o_ir_we     = 1'b0;
    bus.o_pc_we     = 1'b0;
    bus.o_pc_src    = PC_ALU;
    bus.o_reg_we    = 1'b0;
    bus.o_wb_sel    = WB_ALUOUT;
    bus.o_alu_src_a = SA_PC;
    bus.o_alu_src_b = SB_RS2;
    bus.o_imm_sel   = IMM_I;
    bus.o_alu_op    = ALU_ADD;
    if (!rst) begin
      case (r_state)
        ST_FETCH: begin
          bus.o_mem_req   = 1'b1;
          bus.o_alu_src_b = SB_FOUR;
          bus.o_ir_we     = bus.i_mem_ready;
          bus.o_pc_we     = bus.i_mem_ready;
        end
        ST_DECODE: begin
          bus.o_alu_src_a = SA_OLDPC;
          bus.o_alu_src_b = SB_IMM;
          if (bus.i_opcode == OPC_BRANCH)   bus.o_imm_sel = IMM_B;
          else if (bus.i_opcode == OPC_JAL) bus.o_imm_sel = IMM_J;
        end
        ST_EXE_R: begin
          bus.o_alu_src_a = SA_RS1;
          bus.o_alu_op    = w_dec_op;
        end
        ST_EXE_I: begin
          bus.o_alu_src_a = SA_RS1;
          bus.o_alu_src_b = SB_IMM;
          bus.o_alu_op    = w_dec_op;
        end
        ST_ALU_WB: bus.o_reg_we = 1'b1;
        ST_MEM_ADDR: begin
          bus.o_alu_src_a = SA_RS1;
          bus.o_alu_src_b = SB_IMM;
          bus.o_imm_sel   = (bus.i_opcode == OPC_STORE) ? IMM_S : IMM_I;
        end
        ST_MEM_RD: bus.o_mem_req = 1'b1;
        ST_MEM_WB: begin
          bus.o_reg_we = 1'b1;
          bus.o_wb_sel = WB_MDR;
        end
        ST_MEM_WR: begin
          bus.o_mem_req = 1'b1;
          bus.o_mem_we  = 1'b1;
        end
        ST_BRANCH: begin
          bus.o_alu_src_a = SA_RS1;
          bus.o_alu_op    = ALU_SUB;
          bus.o_pc_src    = PC_ALUOUT;
          if (bus.i_funct3 == 3'b000)      bus.o_pc_we = bus.i_zero;
          else if (bus.i_funct3 == 3'b001) bus.o_pc_we = ~bus.i_zero;
        end
        ST_JAL: begin
          bus.o_reg_we = 1'b1;
          bus.o_wb_sel = WB_PC;
          bus.o_pc_we  = 1'b1;
          bus.o_pc_src = PC_ALUOUT;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: an instruction-level model expands each instruction into its
// expected per-cycle strobe pattern and retire count.
module tb_mc_ctrl_fsm;
  import mc_ctrl_fsm_pkg::*;

  localparam int CNT_W       = 6;
  localparam int MEM_TIMEOUT = 15;
  localparam logic [19:0] FULL     = 20'hFFFFF;
  localparam logic [19:0] NO_ALUOP = 20'hFFFF1;

  typedef struct {
    logic        rdy;
    logic        zero;
    logic [19:0] exp;
    logic [19:0] mask;
  } cyc_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_instr  = 0;
  int   retired  = 0;
  cyc_t q[$];

  mc_ctrl_fsm_if #(.CNT_W(CNT_W)) bus ();

  mc_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic mreq, input logic mwe, input logic irwe,
                                     input logic pcwe, input logic [1:0] pcsrc, input logic regwe,
                                     input logic [1:0] wb, input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] imm, input logic [2:0] aop, input logic e);
    return {mreq, mwe, irwe, pcwe, pcsrc, regwe, wb, sa, sb, imm, aop, e};
  endfunction

  function automatic logic [19:0] observed();
    return {bus.o_mem_req, bus.o_mem_we, bus.o_ir_we, bus.o_pc_we, bus.o_pc_src, bus.o_reg_we,
            bus.o_wb_sel, bus.o_alu_src_a, bus.o_alu_src_b, bus.o_imm_sel, bus.o_alu_op, bus.o_err};
  endfunction

  function automatic cyc_t cyc(input logic rdy, input logic zero, input logic [19:0] exp,
                               input logic [19:0] mask);
    cyc_t c;
    c.rdy = rdy; c.zero = zero; c.exp = exp; c.mask = mask;
    return c;
  endfunction

  // Reference ALU op table: {illegal, op}
  function automatic logic [3:0] ref_alu(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return {1'b0, (is_r && f7) ? 3'b110 : 3'b010};
      3'b100:  return 4'b0011;
      3'b110:  return 4'b0001;
      3'b111:  return 4'b0000;
      3'b010:  return 4'b0111;
      3'b101:  return f7 ? 4'b1101 : 4'b0101;
      default: return 4'b1010;
    endcase
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // One memory access: d cycles without ready, then the ready cycle, unless d exceeds the budget.
  task automatic push_access(input int d, input logic fetch, input logic we, output bit bad);
    logic [19:0] v_wait, v_done;
    v_wait = fetch ? mk(1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd2, 3'd0, 3'b010, 0)
                   : mk(1, we, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'b010, 0);
    v_done = fetch ? mk(1, 0, 1, 1, 2'd0, 0, 2'd0, 2'd0, 2'd2, 3'd0, 3'b010, 0) : v_wait;
    bad = (d > MEM_TIMEOUT);
    for (int k = 0; k < (bad ? MEM_TIMEOUT + 1 : d); k++)
      q.push_back(cyc(1'b0, rnd(), v_wait, FULL));
    if (!bad) q.push_back(cyc(1'b1, rnd(), v_done, FULL));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_mem_ready = 1'b0;
    #1;
    chk("rst_outputs", 32'(observed()), 32'(mk(0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'b010, 0)));
    chk("rst_instret", 32'(bus.o_instret), 32'd0);
    retired = 0;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z,
                           input int df, input int dm, input int stop);
    bit          bad, ret;
    logic [3:0]  ao;
    logic [2:0]  imm;
    logic        tk;
    q.delete();
    ret = 0;
    n_instr++;
    push_access(df, 1'b1, 1'b0, bad);
    if (!bad) begin
      imm = (op == OPC_BRANCH) ? 3'd2 : (op == OPC_JAL) ? 3'd3 : 3'd0;
      q.push_back(cyc(rnd(), rnd(), mk(0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd2, 2'd1, imm, 3'b010, 0), FULL));
      case (op)
        OPC_R, OPC_I: begin
          ao = ref_alu(op == OPC_R, f3, f7);
          q.push_back(cyc(rnd(), rnd(), mk(0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd1,
                          (op == OPC_R) ? 2'd0 : 2'd1, 3'd0, ao[2:0], 0), ao[3] ? NO_ALUOP : FULL));
          bad = ao[3];
          if (!bad) begin
            q.push_back(cyc(rnd(), rnd(), mk(0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 3'b010, 0), FULL));
            ret = 1;
          end
        end
        OPC_LOAD, OPC_STORE: begin
          q.push_back(cyc(rnd(), rnd(), mk(0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd1, 2'd1,
                          (op == OPC_STORE) ? 3'd1 : 3'd0, 3'b010, 0), FULL));
          if (f3 != 3'b010) bad = 1;
          else begin
            push_access(dm, 1'b0, op == OPC_STORE, bad);
            if (!bad) begin
              if (op == OPC_LOAD)
                q.push_back(cyc(rnd(), rnd(), mk(0, 0, 0, 0, 2'd0, 1, 2'd1, 2'd0, 2'd0, 3'd0, 3'b010, 0), FULL));
              ret = 1;
            end
          end
        end
        OPC_BRANCH: begin
          tk = (f3 == 3'b000) ? z : (f3 == 3'b001) ? ~z : 1'b0;
          q.push_back(cyc(rnd(), z, mk(0, 0, 0, tk, 2'd1, 0, 2'd0, 2'd1, 2'd0, 3'd0, 3'b110, 0), FULL));
          bad = (f3 > 3'b001);
          ret = !bad;
        end
        OPC_JAL: begin
          q.push_back(cyc(rnd(), rnd(), mk(0, 0, 0, 1, 2'd1, 1, 2'd2, 2'd0, 2'd0, 3'd0, 3'b010, 0), FULL));
          ret = 1;
        end
        default: bad = 1;
      endcase
    end
    if (bad)
      repeat (2) q.push_back(cyc(rnd(), rnd(), mk(0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'b010, 1), FULL));

    for (int i = 0; i < q.size() && (stop < 0 || i < stop); i++) begin
      @(negedge clk);
      rst = 1'b0;
      if (i == 0) begin
        bus.i_opcode   = op;
        bus.i_funct3   = f3;
        bus.i_funct7_5 = f7;
        chk($sformatf("instret_i%0d", n_instr), 32'(bus.o_instret), 32'(retired));
      end
      bus.i_mem_ready = q[i].rdy;
      bus.i_zero      = q[i].zero;
      #1;
      chk($sformatf("i%0d_op%h_c%0d", n_instr, op, i), 32'(observed() & q[i].mask),
          32'(q[i].exp & q[i].mask));
    end
    if (stop < 0) begin
      if (ret) retired = (retired + 1) % (1 << CNT_W);
      if (bad) do_reset();
    end
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    int         sel, r, df, dm;
    rst = 1'b1;
    bus.i_opcode = '0; bus.i_funct3 = '0; bus.i_funct7_5 = 1'b0;
    bus.i_zero = 1'b0; bus.i_mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 32'(observed()), 32'(mk(0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'b010, 0)));
    chk("reset_instret", 32'(bus.o_instret), 32'd0);

    run_instr(OPC_R,      3'b000, 1'b0, 1'b0, 0, 0, -1);   // add
    run_instr(OPC_R,      3'b000, 1'b1, 1'b0, 0, 0, -1);   // sub
    run_instr(OPC_I,      3'b101, 1'b0, 1'b0, 1, 0, -1);   // srli
    run_instr(OPC_I,      3'b101, 1'b1, 1'b0, 0, 0, -1);   // srai -> error
    run_instr(OPC_BRANCH, 3'b000, 1'b0, 1'b1, 0, 0, -1);   // beq taken
    run_instr(OPC_BRANCH, 3'b000, 1'b0, 1'b0, 0, 0, -1);   // beq not taken
    run_instr(OPC_BRANCH, 3'b001, 1'b0, 1'b0, 0, 0, -1);   // bne taken
    run_instr(OPC_LOAD,   3'b010, 1'b0, 1'b0, 0, 3, -1);   // lw, 3 wait cycles
    run_instr(OPC_JAL,    3'b000, 1'b0, 1'b0, 0, 0, -1);
    run_instr(OPC_STORE,  3'b010, 1'b0, 1'b0, 2, 1, -1);
    run_instr(OPC_R,      3'b111, 1'b0, 1'b0, 15, 0, -1);  // longest legal fetch wait
    run_instr(OPC_LOAD,   3'b010, 1'b0, 1'b0, 0, 15, -1);  // longest legal data wait
    run_instr(OPC_R,      3'b000, 1'b0, 1'b0, 16, 0, -1);  // fetch timeout
    run_instr(OPC_STORE,  3'b010, 1'b0, 1'b0, 0, 16, -1);  // write timeout

    // Reset in the middle of a pending store.
    run_instr(OPC_STORE, 3'b010, 1'b0, 1'b0, 0, 5, 4);
    @(negedge clk);
    bus.i_mem_ready = 1'b0;
    #1;
    chk("wr_pending", {30'd0, bus.o_mem_req, bus.o_mem_we}, 32'd3);
    rst = 1'b1;
    #1;
    chk("wr_rst_drop", {30'd0, bus.o_mem_req, bus.o_mem_we}, 32'd0);
    chk("wr_rst_instret", 32'(bus.o_instret), 32'd0);
    retired = 0;

    for (int n = 0; n < 220; n++) begin
      sel = $urandom_range(0, 9);
      f3  = 3'($urandom_range(0, 7));
      case (sel)
        0, 1:    op = OPC_R;
        2, 3:    op = OPC_I;
        4:       op = OPC_LOAD;
        5:       op = OPC_STORE;
        6:       op = OPC_BRANCH;
        7, 8:    op = OPC_JAL;
        default: begin
          op = 7'($urandom_range(0, 127));
          if (op inside {OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL}) op = 7'b1111111;
        end
      endcase
      if ((op == OPC_LOAD || op == OPC_STORE) && $urandom_range(0, 3) != 0) f3 = 3'b010;
      if (op == OPC_BRANCH && $urandom_range(0, 3) != 0) f3 = {2'b00, rnd()};
      r  = $urandom_range(0, 59);
      df = (r == 0) ? 16 : (r == 1) ? 15 : $urandom_range(0, 3);
      r  = $urandom_range(0, 39);
      dm = (r == 0) ? 16 : (r == 1) ? 15 : $urandom_range(0, 3);
      run_instr(op, f3, ($urandom_range(0, 3) == 0), rnd(), df, dm, -1);
    end

    @(negedge clk);
    rst = 1'b0;
    bus.i_mem_ready = 1'b0;
    #1;
    chk("final_instret", 32'(bus.o_instret), 32'(retired));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
